// File: rtl/dense_bram_loader.sv
// dense_bram_loader
// Write-side front end for the dense waveform BRAM. Packs an incoming
// valid/ready/last sample stream into DATA_WIDTH-bit lines (MSB = last-line
// flag), writes them to sequential BRAM addresses starting at 0, and hands the
// BRAM over to playback once the waveform has been loaded.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a load (honoured only when idle)
//   s_data/s_valid/s_last/s_ready   sample stream in
//   write_rdy       BRAM side can accept a write this cycle
//   addr, line_in, we, en           BRAM write port (en mirrors we)
//   generator_mode  playback request, set when a load completes
//   rst_gen_mode    1-cycle pulse restarting playback at address 0
//   lines_written   lines committed in the current/last load
//   busy, done      load in progress / 1-cycle completion pulse
//   overflow        sticky: waveform longer than BRAM_DEPTH lines
`timescale 1ns/1ps
module dense_bram_loader #(
  parameter int DATA_WIDTH   = 257,
  parameter int BRAM_DEPTH   = 600,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SAMPLE_WIDTH-1:0]       s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  input  logic                          write_rdy,
  output logic [$clog2(BRAM_DEPTH)-1:0] addr,
  output logic [DATA_WIDTH-1:0]         line_in,
  output logic                          we,
  output logic                          en,
  output logic                          generator_mode,
  output logic                          rst_gen_mode,
  output logic [$clog2(BRAM_DEPTH):0]   lines_written,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int unsigned SPL = (DATA_WIDTH - 1) / SAMPLE_WIDTH;
  localparam int          AW  = $clog2(BRAM_DEPTH);
  localparam int          CW  = $clog2(SPL + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, FILL, WRITE, DRAIN, FINISH} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          line_has_last;
  logic          accept;

  assign accept = s_valid & s_ready;

  // The write strobe is a decode of the registered WRITE state gated by
  // write_rdy, so the write lands in the very cycle write_rdy is high while
  // addr and line_in (both registered) are stable.
  assign we = (state == WRITE) & write_rdy;
  assign en = we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      line_has_last  <= 1'b0;
      s_ready        <= 1'b0;
      addr           <= '0;
      line_in        <= '0;
      generator_mode <= 1'b0;
      rst_gen_mode   <= 1'b0;
      lines_written  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= FILL;
            s_ready        <= 1'b1;
            busy           <= 1'b1;
            generator_mode <= 1'b0;
            addr           <= '0;
            lines_written  <= '0;
            overflow       <= 1'b0;
            line_in        <= '0;
            count          <= '0;
            line_has_last  <= 1'b0;
          end
        end

        FILL: begin
          if (accept) begin
            for (int unsigned k = 0; k < SPL; k++) begin
              if (count == CW'(k)) begin
                line_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_data;
              end
            end
            count <= count + 1'b1;
            if (s_last || count == CW'(SPL - 1)) begin
              state         <= WRITE;
              s_ready       <= 1'b0;
              line_has_last <= s_last;
              // The final BRAM line always carries the terminator so playback
              // stops even when the waveform is truncated.
              line_in[DATA_WIDTH-1] <= s_last | (addr == LAST_ADDR);
            end
          end
        end

        WRITE: begin
          if (write_rdy) begin
            lines_written <= lines_written + 1'b1;
            if (line_has_last) begin
              state          <= FINISH;
              done           <= 1'b1;
              rst_gen_mode   <= 1'b1;
              generator_mode <= 1'b1;
            end else if (addr == LAST_ADDR) begin
              overflow <= 1'b1;
              state    <= DRAIN;
              s_ready  <= 1'b1;
            end else begin
              addr    <= addr + 1'b1;
              line_in <= '0;
              count   <= '0;
              state   <= FILL;
              s_ready <= 1'b1;
            end
          end
        end

        DRAIN: begin
          if (accept && s_last) begin
            state          <= FINISH;
            s_ready        <= 1'b0;
            done           <= 1'b1;
            rst_gen_mode   <= 1'b1;
            generator_mode <= 1'b1;
          end
        end

        FINISH: begin
          done         <= 1'b0;
          rst_gen_mode <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
